// File: rtl/ctr_retire_align.sv
// Aligns the retire streams of two redundant cores into instruction pairs for comparison.
// Latency: a pair is presented two cycles after the later of the two partner retires.
// Backpressure: stall_k_o rises when FIFO k is full or checking has ended; a retire into a full FIFO with no same-cycle pop is an overflow error.
module ctr_retire_align #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             retire_1_i,
  input  logic             retire_2_i,
  input  logic [31:0]      instr_1_i,
  input  logic [31:0]      instr_2_i,
  input  logic [7:0][31:0] regfile_1_i,
  input  logic [7:0][31:0] regfile_2_i,
  input  logic             halt_1_i,
  input  logic             halt_2_i,
  output logic             stall_1_o,
  output logic             stall_2_o,
  output logic             pair_valid_o,
  output logic [31:0]      instr_1_o,
  output logic [31:0]      instr_2_o,
  output logic [1:0][31:0] opnd_1_o,
  output logic [1:0][31:0] opnd_2_o,
  output logic [31:0]      pair_cnt_o,
  output logic             done_o,
  output logic             error_o,
  output logic [1:0]       err_cause_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_OVF = 2'd1;
  localparam logic [1:0] CAUSE_MIS = 2'd2;
  localparam logic [1:0] CAUSE_TMO = 2'd3;

  // One retire record: the instruction plus its two source operands as seen at retire.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs2_val;
    logic [31:0] rs1_val;
  } entry_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic [1:0] cause_nxt;

  // Per-core views of the ports so both FIFOs share one description.
  logic             retire   [2];
  logic [31:0]      instr_in [2];
  logic [7:0][31:0] rf       [2];
  logic             halt     [2];
  entry_t           wr_entry [2];
  entry_t           head     [2];
  logic             empty    [2];
  logic             full     [2];
  logic             push     [2];

  logic          active;
  logic          pop;
  logic          ovf;
  logic          mis;
  logic          one_busy;
  logic          tmo;
  logic [TW-1:0] tmo_cnt;

  assign retire[0]   = retire_1_i;
  assign retire[1]   = retire_2_i;
  assign instr_in[0] = instr_1_i;
  assign instr_in[1] = instr_2_i;
  assign rf[0]       = regfile_1_i;
  assign rf[1]       = regfile_2_i;
  assign halt[0]     = halt_1_i;
  assign halt[1]     = halt_2_i;

  for (genvar k = 0; k < 2; k++) begin : g_core
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    entry_t        mem [DEPTH];

    // Only the low three bits of each source field address the 8-entry register file.
    assign wr_entry[k] = {instr_in[k], rf[k][instr_in[k][2:0]], rf[k][instr_in[k][10:8]]};
    assign empty[k]    = (cnt_q == '0);
    assign full[k]     = (cnt_q == FULL_CNT);
    // A full FIFO still takes a retire when its head leaves in the same cycle.
    assign push[k]     = active && retire[k] && (!full[k] || pop);
    assign head[k]     = mem[rd_ptr];

    // Pointer and occupancy tracking; push and pop together leave the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt_q  <= '0;
      end else begin
        if (push[k]) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({push[k], pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    // Entry storage; contents are only read once the count marks them valid, so no bypass exists.
    always_ff @(posedge clk_i) begin
      if (push[k]) mem[wr_ptr] <= wr_entry[k];
    end
  end

  assign active   = (state == S_RUN) || (state == S_DRAIN);
  assign pop      = active && !empty[0] && !empty[1];
  assign one_busy = empty[0] ^ empty[1];

  assign ovf = active && ((retire[0] && full[0] && !pop) ||
                          (retire[1] && full[1] && !pop));

  // A halted core with nothing left to give while its partner still waits can never be paired.
  assign mis = active && ((halt[0] && empty[0] && !push[0] && !empty[1]) ||
                          (halt[1] && empty[1] && !push[1] && !empty[0]));

  assign tmo = active && one_busy && (tmo_cnt == TMO_LAST);

  assign stall_1_o = full[0] || !active;
  assign stall_2_o = full[1] || !active;

  // Counts consecutive cycles in which exactly one side holds entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
    end else if (!active || !one_busy) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Next-state and error-cause selection; overflow outranks mismatch, which outranks timeout.
  always_comb begin
    state_nxt = state;
    cause_nxt = err_cause_o;
    case (state)
      S_RUN, S_DRAIN: begin
        if (ovf) begin
          state_nxt = S_ERROR;
          cause_nxt = CAUSE_OVF;
        end else if (mis) begin
          state_nxt = S_ERROR;
          cause_nxt = CAUSE_MIS;
        end else if (tmo) begin
          state_nxt = S_ERROR;
          cause_nxt = CAUSE_TMO;
        end else if (state == S_RUN) begin
          if (halt_1_i || halt_2_i) state_nxt = S_DRAIN;
        end else if (halt_1_i && halt_2_i && empty[0] && empty[1] && !push[0] && !push[1]) begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end

  // State register with registered status flags derived from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_RUN;
      err_cause_o <= '0;
      error_o     <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      err_cause_o <= cause_nxt;
      error_o     <= (state_nxt == S_ERROR);
      done_o      <= (state_nxt == S_DONE);
    end
  end

  // Pair output register; data holds between pairs so only pair_valid_o pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pair_valid_o <= 1'b0;
      instr_1_o    <= '0;
      instr_2_o    <= '0;
      opnd_1_o     <= '0;
      opnd_2_o     <= '0;
      pair_cnt_o   <= '0;
    end else begin
      pair_valid_o <= pop;
      if (pop) begin
        instr_1_o  <= head[0].instr;
        instr_2_o  <= head[1].instr;
        opnd_1_o   <= {head[0].rs2_val, head[0].rs1_val};
        opnd_2_o   <= {head[1].rs2_val, head[1].rs1_val};
        pair_cnt_o <= pair_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ctr_retire_align.sv
// Scoreboard bench for the dual-core retire aligner.
// Stimulus queues expected per-core retires; a negedge monitor pairs them and checks each presented pair.
// Status outputs (stall, done, error, cause) are checked directly by the directed sequences.
module tb_ctr_retire_align;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             retire_1_i = 1'b0;
  logic             retire_2_i = 1'b0;
  logic [31:0]      instr_1_i = '0;
  logic [31:0]      instr_2_i = '0;
  logic [7:0][31:0] rf1 = '0;
  logic [7:0][31:0] rf2 = '0;
  logic             halt_1_i = 1'b0;
  logic             halt_2_i = 1'b0;
  logic             stall_1_o;
  logic             stall_2_o;
  logic             pair_valid_o;
  logic [31:0]      instr_1_o;
  logic [31:0]      instr_2_o;
  logic [1:0][31:0] opnd_1_o;
  logic [1:0][31:0] opnd_2_o;
  logic [31:0]      pair_cnt_o;
  logic             done_o;
  logic             error_o;
  logic [1:0]       err_cause_o;

  ctr_retire_align #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .retire_1_i   (retire_1_i),
    .retire_2_i   (retire_2_i),
    .instr_1_i    (instr_1_i),
    .instr_2_i    (instr_2_i),
    .regfile_1_i  (rf1),
    .regfile_2_i  (rf2),
    .halt_1_i     (halt_1_i),
    .halt_2_i     (halt_2_i),
    .stall_1_o    (stall_1_o),
    .stall_2_o    (stall_2_o),
    .pair_valid_o (pair_valid_o),
    .instr_1_o    (instr_1_o),
    .instr_2_o    (instr_2_o),
    .opnd_1_o     (opnd_1_o),
    .opnd_2_o     (opnd_2_o),
    .pair_cnt_o   (pair_cnt_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .err_cause_o  (err_cause_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] opnd;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  exp_t        e1;
  exp_t        e2;
  logic [31:0] exp_cnt = '0;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Expected operand word {regfile[rs2], regfile[rs1]}, using the low three bits of each field.
  function automatic logic [63:0] opnd_of(input logic [7:0][31:0] rf, input logic [31:0] ins);
    logic [2:0] s1;
    logic [2:0] s2;
    s1 = ins[10:8];
    s2 = ins[2:0];
    return {rf[s2], rf[s1]};
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] rs1, input logic [7:0] rs2);
    return {op, 8'h00, rs1, rs2};
  endfunction

  task automatic fill_rf(input logic [7:0] stamp);
    for (int i = 0; i < 8; i++) begin
      rf1[i] = {8'h10, 8'h00, stamp, 8'(i)};
      rf2[i] = {8'h20, 8'h00, stamp, 8'(i)};
    end
  endtask

  task automatic drive(input logic r1, input logic [31:0] i1, input logic r2, input logic [31:0] i2);
    retire_1_i = r1;
    instr_1_i  = i1;
    retire_2_i = r2;
    instr_2_i  = i2;
    @(posedge clk_i);
    #1;
    retire_1_i = 1'b0;
    retire_2_i = 1'b0;
  endtask

  task automatic retire(input logic r1, input logic [31:0] i1, input logic r2, input logic [31:0] i2);
    if (r1) q1.push_back({i1, opnd_of(rf1, i1)});
    if (r2) q2.push_back({i2, opnd_of(rf2, i2)});
    drive(r1, i1, r2, i2);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    retire_1_i = 1'b0;
    retire_2_i = 1'b0;
    halt_1_i   = 1'b0;
    halt_2_i   = 1'b0;
    q1.delete();
    q2.delete();
    exp_cnt = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pair_valid"}, 64'(pair_valid_o), 64'd0);
    chk({tag, "_pair_cnt"},   64'(pair_cnt_o),   64'd0);
    chk({tag, "_instr_1"},    64'(instr_1_o),    64'd0);
    chk({tag, "_instr_2"},    64'(instr_2_o),    64'd0);
    chk({tag, "_opnd_1"},     64'(opnd_1_o),     64'd0);
    chk({tag, "_opnd_2"},     64'(opnd_2_o),     64'd0);
    chk({tag, "_done"},       64'(done_o),       64'd0);
    chk({tag, "_error"},      64'(error_o),      64'd0);
    chk({tag, "_cause"},      64'(err_cause_o),  64'd0);
    chk({tag, "_stall_1"},    64'(stall_1_o),    64'd0);
    chk({tag, "_stall_2"},    64'(stall_2_o),    64'd0);
  endtask

  // Monitor: every presented pair must match the oldest pending retire of each core.
  always @(negedge clk_i) begin
    if (rst_ni && pair_valid_o) begin
      if (q1.size() == 0 || q2.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_pair: got pair_valid_o=1 instr_1=0x%0h, want no pair pending", instr_1_o);
      end else begin
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        exp_cnt = exp_cnt + 32'd1;
        chk("pair_instr_1", 64'(instr_1_o), 64'(e1.instr));
        chk("pair_instr_2", 64'(instr_2_o), 64'(e2.instr));
        chk("pair_opnd_1",  opnd_1_o,       e1.opnd);
        chk("pair_opnd_2",  opnd_2_o,       e2.opnd);
        chk("pair_cnt",     64'(pair_cnt_o), 64'(exp_cnt));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no summary by time limit, want completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] ia, ib, ic, id;
  logic        seen;

  initial begin
    ia = mk(8'h0A, 8'h0B, 8'h02);
    ib = mk(8'h0B, 8'h05, 8'h1E);
    ic = mk(8'h0C, 8'h07, 8'h00);
    id = mk(8'h0D, 8'h01, 8'h04);

    // Reset values, both during and after reset.
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("rst_low");
    do_reset();
    check_zero("rst_rel");

    // Lockstep: identical retire on both cores, pair two cycles later.
    rf1 = '0;
    rf2 = '0;
    rf1[3] = 32'd5; rf1[4] = 32'd7;
    rf2[3] = 32'd5; rf2[4] = 32'd7;
    retire(1'b1, 32'h0102_0304, 1'b1, 32'h0102_0304);
    rf1 = '1;
    rf2 = '1;
    @(negedge clk_i);
    chk("lock_valid_p1", 64'(pair_valid_o), 64'd0);
    @(negedge clk_i);
    chk("lock_valid_p2", 64'(pair_valid_o), 64'd1);
    chk("lock_opnd_1",   opnd_1_o, {32'd7, 32'd5});
    chk("lock_opnd_2",   opnd_2_o, {32'd7, 32'd5});
    chk("lock_cnt",      64'(pair_cnt_o), 64'd1);
    @(negedge clk_i);
    chk("lock_valid_p3", 64'(pair_valid_o), 64'd0);

    // Skew: core 2 lags core 1 by three cycles; operands change every cycle.
    do_reset();
    fill_rf(8'h01); retire(1'b1, ia, 1'b0, '0);
    fill_rf(8'h02); retire(1'b1, ib, 1'b0, '0);
    fill_rf(8'h03); retire(1'b1, ic, 1'b0, '0);
    fill_rf(8'h04); retire(1'b0, '0, 1'b1, ia);
    fill_rf(8'h05); retire(1'b0, '0, 1'b1, ib);
    fill_rf(8'h06); retire(1'b0, '0, 1'b1, ic);
    idle(6);
    @(negedge clk_i);
    chk("skew_error",   64'(error_o),    64'd0);
    chk("skew_cnt",     64'(pair_cnt_o), 64'd3);
    chk("skew_pending", 64'(q1.size() + q2.size()), 64'd0);

    // Overflow: core 1 fills its FIFO, then retires again with no pop.
    do_reset();
    fill_rf(8'h10);
    for (int i = 0; i < DEPTH; i++) retire(1'b1, mk(8'(8'h50 + i), 8'(i), 8'(i + 1)), 1'b0, '0);
    @(negedge clk_i);
    chk("bp_stall_1", 64'(stall_1_o), 64'd1);
    chk("bp_stall_2", 64'(stall_2_o), 64'd0);
    chk("bp_error",   64'(error_o),   64'd0);
    drive(1'b1, mk(8'h5F, 8'h00, 8'h00), 1'b0, '0);
    @(negedge clk_i);
    chk("ovf_error",   64'(error_o),     64'd1);
    chk("ovf_cause",   64'(err_cause_o), 64'd1);
    chk("ovf_stall_2", 64'(stall_2_o),   64'd1);

    // Full FIFO accepts a retire in the same cycle its head is popped.
    do_reset();
    fill_rf(8'h20);
    for (int i = 0; i < DEPTH; i++) retire(1'b1, mk(8'(8'h60 + i), 8'(i), 8'(i + 2)), 1'b0, '0);
    @(negedge clk_i);
    chk("fp_stall_1", 64'(stall_1_o), 64'd1);
    retire(1'b0, '0, 1'b1, mk(8'h60, 8'h00, 8'h02));
    fill_rf(8'h21);
    retire(1'b1, mk(8'h64, 8'h04, 8'h06), 1'b1, mk(8'h61, 8'h01, 8'h03));
    retire(1'b0, '0, 1'b1, mk(8'h62, 8'h02, 8'h04));
    retire(1'b0, '0, 1'b1, mk(8'h63, 8'h03, 8'h05));
    retire(1'b0, '0, 1'b1, mk(8'h64, 8'h04, 8'h06));
    idle(5);
    @(negedge clk_i);
    chk("fp_error",   64'(error_o),    64'd0);
    chk("fp_cnt",     64'(pair_cnt_o), 64'd5);
    chk("fp_pending", 64'(q1.size() + q2.size()), 64'd0);

    // Timeout: one lone entry trips the timer exactly TIMEOUT cycles after it becomes visible.
    do_reset();
    fill_rf(8'h30);
    retire(1'b1, ia, 1'b0, '0);
    repeat (TIMEOUT - 1) @(posedge clk_i);
    @(negedge clk_i);
    chk("tmo_early_error", 64'(error_o), 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("tmo_error", 64'(error_o),     64'd1);
    chk("tmo_cause", 64'(err_cause_o), 64'd3);

    // Clean drain: two pairs then both cores halt.
    do_reset();
    fill_rf(8'h40);
    retire(1'b1, ia, 1'b1, ia);
    retire(1'b1, ib, 1'b1, ib);
    halt_1_i = 1'b1;
    halt_2_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("drain_done",    64'(seen),       64'd1);
    chk("drain_error",   64'(error_o),    64'd0);
    chk("drain_cnt",     64'(pair_cnt_o), 64'd2);
    chk("drain_stall_1", 64'(stall_1_o),  64'd1);
    chk("drain_pending", 64'(q1.size() + q2.size()), 64'd0);

    // Count mismatch: core 2 halts after a single retire while core 1 has a second.
    do_reset();
    fill_rf(8'h50);
    retire(1'b1, ia, 1'b1, ia);
    halt_2_i = 1'b1;
    retire(1'b1, ib, 1'b0, '0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (error_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mis_error", 64'(seen),        64'd1);
    chk("mis_cause", 64'(err_cause_o), 64'd2);
    chk("mis_cnt",   64'(pair_cnt_o),  64'd1);

    // Reset mid-run with two entries waiting in FIFO 1.
    do_reset();
    fill_rf(8'h60);
    retire(1'b1, ia, 1'b1, ia);
    retire(1'b1, ib, 1'b0, '0);
    retire(1'b1, ic, 1'b0, '0);
    @(negedge clk_i);
    chk("mid_pre_cnt", 64'(pair_cnt_o), 64'd1);
    rst_ni = 1'b0;
    q1.delete();
    q2.delete();
    exp_cnt = '0;
    #2;
    check_zero("mid_rst");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    fill_rf(8'h61);
    retire(1'b1, id, 1'b1, id);
    idle(3);
    @(negedge clk_i);
    chk("mid_post_cnt",   64'(pair_cnt_o), 64'd1);
    chk("mid_post_instr", 64'(instr_1_o),  64'(id));
    chk("mid_post_error", 64'(error_o),    64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ctr_retire_align.md
CTR_RETIRE_ALIGN -- requirements
Module: ctr_retire_align

Interface
REQ-001 SHALL have parameter DEPTH, default 4, per-core retire FIFO depth, power of 2, minimum 2.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum cycles one FIFO may hold entries while the other is empty.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports retire_1_i / retire_2_i, input, 1, core k retires one instruction this cycle.
REQ-006 SHALL have ports instr_1_i / instr_2_i, input, 32, retiring instruction {op[31:24], rd[23:16], rs1[15:8], rs2[7:0]}.
REQ-007 SHALL have ports regfile_1_i / regfile_2_i, input, 8x32, core k register file at retire.
REQ-008 SHALL have ports halt_1_i / halt_2_i, input, 1, core k has stopped retiring (level, sticky at source).
REQ-009 SHALL have ports stall_1_o / stall_2_o, output, 1, core k must not retire next cycle.
REQ-010 SHALL have port pair_valid_o, output, 1, one aligned retire pair presented this cycle.
REQ-011 SHALL have ports instr_1_o / instr_2_o, output, 32, paired instructions.
REQ-012 SHALL have ports opnd_1_o / opnd_2_o, output, 2x32, {regfile[rs2], regfile[rs1]} captured at retire.
REQ-013 SHALL have port pair_cnt_o, output, 32, number of pairs emitted, wraps modulo 2^32.
REQ-014 SHALL have ports done_o / error_o, output, 1 each; err_cause_o, output, 2: 0 none, 1 overflow, 2 count mismatch, 3 timeout.

Function
REQ-015 SHALL, on retire_k_i, push {instr, regfile[rs1[2:0]], regfile[rs2[2:0]]} into FIFO k; upper bits of rs fields are ignored.
REQ-016 SHALL drive stall_k_o = 1 combinationally when FIFO k count == DEPTH, or when the state is DONE or ERROR.
REQ-017 SHALL accept a retire into a full FIFO only if that FIFO pops in the same cycle; otherwise drop the entry and enter ERROR with cause 1.
REQ-018 SHALL pop both FIFO heads in any cycle where both are non-empty in RUN or DRAIN, and register them to outputs with pair_valid_o = 1 on the next cycle; otherwise pair_valid_o = 0 and data outputs hold.
REQ-019 SHALL make pushed entries visible at the head one cycle after the push (no bypass); simultaneous retires into empty FIFOs yield pair_valid_o exactly 2 cycles later.
REQ-020 SHALL preserve retire order per core, and pair the i-th retire of core 1 with the i-th retire of core 2.
REQ-021 SHALL increment pair_cnt_o in the cycle pair_valid_o is asserted.
REQ-022 SHALL implement FSM RUN -> DRAIN when either halt_k_i = 1; DRAIN -> DONE when both halt_k_i = 1 and both FIFOs are empty; RUN/DRAIN -> ERROR on any error; DONE and ERROR are absorbing until reset.
REQ-023 SHALL continue accepting retires from a non-halted core in DRAIN.
REQ-024 SHALL flag cause 2 when halt_k_i = 1, FIFO k is empty, no push to FIFO k occurs this cycle, and the other FIFO is non-empty.
REQ-025 SHALL count consecutive cycles in which exactly one FIFO is non-empty; the counter resets on any cycle not meeting that condition, and reaching TIMEOUT flags cause 3.
REQ-026 SHALL resolve simultaneous errors with priority overflow > mismatch > timeout, latching only the highest-priority cause.
REQ-027 SHALL assert error_o whenever the state is ERROR and done_o whenever the state is DONE; both are registered.

Reset
REQ-028 SHALL, while rst_ni = 0, clear both FIFOs, the timeout counter, pair_cnt_o, pair_valid_o, instr/opnd outputs, done_o, error_o, and err_cause_o to 0, and set the state to RUN.
REQ-029 SHALL discard in-flight entries on reset assertion mid-operation, with the first pair after release formed only from post-reset retires.

Verification
REQ-030 SHALL cover lockstep: both cores retire 0x01020304 with regfile[3]=5, regfile[4]=7 in the same cycle -> pair_valid_o at +2 cycles, opnd = {7,5}, pair_cnt_o = 1.
REQ-031 SHALL cover skew: core 1 retires A,B,C; core 2 retires A,B,C 3 cycles later -> three pairs in order (A,A),(B,B),(C,C), error_o = 0.
REQ-032 SHALL cover backpressure: DEPTH=4, core 1 retires 4 times while core 2 idles -> stall_1_o = 1; a 5th core-1 retire with no pop -> error_o = 1, err_cause_o = 1.
REQ-033 SHALL cover timeout: core 1 retires once, core 2 silent -> err_cause_o = 3 exactly TIMEOUT cycles after the entry becomes visible.
REQ-034 SHALL cover drain: both cores retire 2 instructions then halt -> done_o = 1 after the last pair; if core 2 halts after only 1 retire -> err_cause_o = 2.
REQ-035 SHALL cover reset mid-run: rst_ni pulsed low with 2 entries in FIFO 1 -> all outputs 0 and state RUN; the next paired retires produce pair_cnt_o = 1.
